// File: rtl/eeg_dat_rx_pkg.sv
// eeg_dat_rx_pkg: shared types and sizes for the EEG chip-side receive stage.
// Holds the packer state enum, the FIFO entry struct and the beat/word geometry.
package eeg_dat_rx_pkg;

  localparam int DAT_W     = 8;
  localparam int WORD_W    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int R         = WORD_W / DAT_W;
  localparam int CNT_W     = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PACK_DAT = 2'd1,
    PACK_CMD = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic              is_cmd;
    logic              lst;
    logic [WORD_W-1:0] word;
  } rx_entry_t;

endpackage

// File: rtl/eeg_rx_fifo.sv
// eeg_rx_fifo: synchronous FIFO of rx_entry_t with empty flag and entry count.
// Ports: clk, rst, push_i/wdata_i, pop_i, rdata_o (head), empty_o, count_o.
module eeg_rx_fifo
  import eeg_dat_rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  rx_entry_t              wdata_i,
  input  logic                   pop_i,
  output rx_entry_t              rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rx_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign push_ok = push_i & (cnt_q != FULL_CNT);
  assign pop_ok  = pop_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/eeg_dat_rx.sv
// eeg_dat_rx: packs CHIP_DAT_* pad beats into words and demuxes them to data/cmd streams.
// Ports: CHIP_DAT_VLD/LST/CMD/DAT in, CHIP_DAT_RDY out; dat_* and cmd_* valid/ready out; err_proto.
// Optional macro EEG_DAT_RX_STAT_EN adds stat_words (words pushed) and stat_drops (partials dropped).
module eeg_dat_rx
  import eeg_dat_rx_pkg::*;
#(
  parameter int CHIP_DAT_DW = DAT_W,
  parameter int WORD_DW     = WORD_W,
  parameter int FIFO_DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CHIP_DAT_VLD,
  input  logic                   CHIP_DAT_LST,
  input  logic                   CHIP_DAT_CMD,
  input  logic [CHIP_DAT_DW-1:0] CHIP_DAT_DAT,
  output logic                   CHIP_DAT_RDY,
  output logic                   dat_vld,
  input  logic                   dat_rdy,
  output logic [WORD_DW-1:0]     dat_dat,
  output logic                   dat_lst,
  output logic                   cmd_vld,
  input  logic                   cmd_rdy,
  output logic [WORD_DW-1:0]     cmd_dat,
`ifdef EEG_DAT_RX_STAT_EN
  output logic [15:0]            stat_words,
  output logic [7:0]             stat_drops,
`endif
  output logic                   err_proto
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] FULL_CNT = FCW'(FIFO_DEPTH);

  rx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_DW-1:0]  word_q, word_d;
  logic                err_q, err_d;

  logic                take, open, cur_cmd, restart;
  logic                typ, done, push, drop;
  logic [CNT_W-1:0]    idx;
  logic [WORD_DW-1:0]  base, word_n;
  rx_entry_t           push_e, head;
  logic                fifo_empty, pop;
  logic [FCW-1:0]      fifo_cnt;

  // Ready comes from the registered count, so a pop never raises it early.
  assign CHIP_DAT_RDY = !rst & (fifo_cnt != FULL_CNT);
  assign take         = CHIP_DAT_VLD & CHIP_DAT_RDY;

  always_comb begin
    cur_cmd = 1'b0;
    open    = 1'b0;
    unique case (state_q)
      PACK_DAT: begin cur_cmd = 1'b0; open = 1'b1; end
      PACK_CMD: begin cur_cmd = 1'b1; open = 1'b1; end
      default:  begin cur_cmd = 1'b0; open = 1'b0; end
    endcase
  end

  // A type change mid-word drops the partial and restarts with this beat.
  assign restart = !open | (CHIP_DAT_CMD != cur_cmd);
  assign drop    = take & open & (CHIP_DAT_CMD != cur_cmd);
  assign typ     = restart ? CHIP_DAT_CMD : cur_cmd;
  assign idx     = restart ? '0 : cnt_q;
  assign base    = restart ? '0 : word_q;
  assign word_n  = base
                 | (WORD_DW'(CHIP_DAT_DAT) << (idx * CHIP_DAT_DW));
  assign done    = CHIP_DAT_LST | (idx == CNT_W'(R - 1));
  assign push    = take & done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    err_d   = err_q | drop;
    push_e  = '0;
    if (take) begin
      if (done) begin
        push_e.is_cmd = typ;
        push_e.lst    = CHIP_DAT_LST & !typ;
        push_e.word   = word_n;
        state_d = IDLE;
        cnt_d   = '0;
        word_d  = '0;
      end else begin
        state_d = typ ? PACK_CMD : PACK_DAT;
        cnt_d   = idx + 1'b1;
        word_d  = word_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  eeg_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_e),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Head is routed by type; a stalled head blocks both streams.
  assign dat_vld   = !fifo_empty & !head.is_cmd;
  assign cmd_vld   = !fifo_empty & head.is_cmd;
  assign dat_dat   = dat_vld ? head.word : '0;
  assign dat_lst   = dat_vld & head.lst;
  assign cmd_dat   = cmd_vld ? head.word : '0;
  assign pop       = (dat_vld & dat_rdy) | (cmd_vld & cmd_rdy);
  assign err_proto = err_q;

`ifdef EEG_DAT_RX_STAT_EN
  logic [15:0] words_q;
  logic [7:0]  drops_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      drops_q <= '0;
    end else begin
      if (push && words_q != 16'hFFFF) words_q <= words_q + 1'b1;
      if (drop && drops_q != 8'hFF)    drops_q <= drops_q + 1'b1;
    end
  end

  assign stat_words = words_q;
  assign stat_drops = drops_q;
`endif

endmodule

// File: tb/tb_eeg_dat_rx.sv
// tb_eeg_dat_rx: directed bench for eeg_dat_rx with a popped-word scoreboard queue.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_eeg_dat_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        CHIP_DAT_VLD, CHIP_DAT_LST, CHIP_DAT_CMD;
  logic [7:0]  CHIP_DAT_DAT;
  logic        CHIP_DAT_RDY;
  logic        dat_vld, dat_rdy, dat_lst;
  logic [31:0] dat_dat;
  logic        cmd_vld, cmd_rdy;
  logic [31:0] cmd_dat;
  logic        err_proto;
`ifdef EEG_DAT_RX_STAT_EN
  logic [15:0] stat_words;
  logic [7:0]  stat_drops;
`endif

  int errors = 0;
  int checks = 0;
  int cmd_cyc = 0;
  int both_cnt = 0;
  int c0;
  logic [33:0] got_q[$];

  always #5 clk = ~clk;

  eeg_dat_rx dut (
    .clk          (clk),
    .rst          (rst),
    .CHIP_DAT_VLD (CHIP_DAT_VLD),
    .CHIP_DAT_LST (CHIP_DAT_LST),
    .CHIP_DAT_CMD (CHIP_DAT_CMD),
    .CHIP_DAT_DAT (CHIP_DAT_DAT),
    .CHIP_DAT_RDY (CHIP_DAT_RDY),
    .dat_vld      (dat_vld),
    .dat_rdy      (dat_rdy),
    .dat_dat      (dat_dat),
    .dat_lst      (dat_lst),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_dat      (cmd_dat),
`ifdef EEG_DAT_RX_STAT_EN
    .stat_words   (stat_words),
    .stat_drops   (stat_drops),
`endif
    .err_proto    (err_proto)
  );

  always @(negedge clk) begin
    if (dat_vld && dat_rdy) got_q.push_back({1'b0, dat_lst, dat_dat});
    if (cmd_vld && cmd_rdy) got_q.push_back({1'b1, 1'b0, cmd_dat});
    if (cmd_vld) cmd_cyc++;
    if (cmd_vld && dat_vld) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic c, input logic l);
    bit ok;
    ok = 1'b0;
    CHIP_DAT_VLD = 1'b1;
    CHIP_DAT_DAT = d;
    CHIP_DAT_CMD = c;
    CHIP_DAT_LST = l;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = CHIP_DAT_RDY;
      @(posedge clk);
      #1;
    end
    CHIP_DAT_VLD = 1'b0;
    CHIP_DAT_LST = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic expect_word(input string tag, input logic [33:0] exp);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 100) begin
      step(1);
      n++;
    end
    if (got_q.size() != 0) chk(tag, 64'(got_q.pop_front()), 64'(exp));
    else chk(tag, 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp));
  endtask

  initial begin
    rst = 1'b1;
    CHIP_DAT_VLD = 1'b0;
    CHIP_DAT_LST = 1'b0;
    CHIP_DAT_CMD = 1'b0;
    CHIP_DAT_DAT = '0;
    dat_rdy = 1'b1;
    cmd_rdy = 1'b1;
    step(2);

    @(negedge clk);
    chk("rst_rdy", 64'(CHIP_DAT_RDY), 64'd0);
    chk("rst_dat_vld", 64'(dat_vld), 64'd0);
    chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
    chk("rst_dat_dat", 64'(dat_dat), 64'd0);
    chk("rst_cmd_dat", 64'(cmd_dat), 64'd0);
    chk("rst_dat_lst", 64'(dat_lst), 64'd0);
    chk("rst_err", 64'(err_proto), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(CHIP_DAT_RDY), 64'd1);
    @(posedge clk);
    #1;

    // Two-word data packet
    c0 = cmd_cyc;
    send(8'h11, 0, 0); send(8'h22, 0, 0);
    send(8'h33, 0, 0); send(8'h44, 0, 0);
    send(8'h55, 0, 0); send(8'h66, 0, 0);
    send(8'h77, 0, 0); send(8'h88, 0, 1);
    expect_word("pkt_w0", {2'b00, 32'h44332211});
    expect_word("pkt_w1", {2'b01, 32'h88776655});
    chk("pkt_no_cmd", 64'(cmd_cyc - c0), 64'd0);

    // Short packet, one-cycle latency
    send(8'hAA, 0, 0);
    chk("short_not_yet", 64'(dat_vld), 64'd0);
    send(8'hBB, 0, 1);
    chk("short_lat_vld", 64'(dat_vld), 64'd1);
    chk("short_lat_dat", 64'(dat_dat), 64'h0000BBAA);
    chk("short_lat_lst", 64'(dat_lst), 64'd1);
    expect_word("short_w", {2'b01, 32'h0000BBAA});

    // Command word
    c0 = cmd_cyc;
    send(8'h01, 1, 0); send(8'h02, 1, 0);
    send(8'h03, 1, 0); send(8'h04, 1, 0);
    expect_word("cmd_w", {2'b10, 32'h04030201});
    step(3);
    chk("cmd_one_cycle", 64'(cmd_cyc - c0), 64'd1);
    chk("cmd_no_extra", 64'(got_q.size()), 64'd0);

    // LST on command beats forces early completion, no dat_lst
    send(8'h05, 1, 0); send(8'h06, 1, 1);
    expect_word("cmd_lst_w", {2'b10, 32'h00000605});

    // Backpressure: 16 beats fill the FIFO
    dat_rdy = 1'b0;
    for (int i = 1; i <= 16; i++) send(8'(i), 0, 0);
    @(negedge clk);
    chk("bp_rdy_low", 64'(CHIP_DAT_RDY), 64'd0);
    chk("bp_no_pop", 64'(got_q.size()), 64'd0);
    @(posedge clk);
    #1;
    step(2);
    chk("bp_rdy_held", 64'(CHIP_DAT_RDY), 64'd0);
    dat_rdy = 1'b1;
    for (int i = 17; i <= 20; i++) send(8'(i), 0, 0);
    expect_word("bp_w0", {2'b00, 32'h04030201});
    expect_word("bp_w1", {2'b00, 32'h08070605});
    expect_word("bp_w2", {2'b00, 32'h0C0B0A09});
    expect_word("bp_w3", {2'b00, 32'h100F0E0D});
    expect_word("bp_w4", {2'b00, 32'h14131211});

    // Protocol error: type flips mid-word
    chk("err_clear", 64'(err_proto), 64'd0);
    send(8'h10, 0, 0); send(8'h20, 0, 0);
    send(8'h30, 1, 0); send(8'h31, 1, 0);
    send(8'h32, 1, 0); send(8'h33, 1, 0);
    chk("err_set", 64'(err_proto), 64'd1);
    expect_word("err_cmd_w", {2'b10, 32'h33323130});
    step(4);
    chk("err_no_extra", 64'(got_q.size()), 64'd0);
    chk("err_sticky", 64'(err_proto), 64'd1);
`ifdef EEG_DAT_RX_STAT_EN
    chk("stat_drops", 64'(stat_drops), 64'd1);
`endif

    // Reset mid-word discards the partial
    send(8'hA1, 0, 0); send(8'hA2, 0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_err_cleared", 64'(err_proto), 64'd0);
    send(8'hB1, 0, 0); send(8'hB2, 0, 0);
    send(8'hB3, 0, 0); send(8'hB4, 0, 0);
    expect_word("rst_mid_w", {2'b00, 32'hB4B3B2B1});
    step(4);
    chk("rst_mid_no_extra", 64'(got_q.size()), 64'd0);
    chk("vld_exclusive", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
